// File: rtl/mode_arbiter.sv
// mode_arbiter: grants the LCD character path and push-switches to one display mode, with frame-aligned blank switching and alarm preemption (idle timeout under `MODE_TIMEOUT_EN`).
module mode_arbiter #(
  parameter int BLANK_CHARS = 32,
  parameter int ALARM_SECS  = 60,
  parameter int IDLE_SECS   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_clk,
  input  logic       en_1hz,
  input  logic [3:0] dip_sw,
  input  logic [3:0] sw_in,
  input  logic       alarm_req,
  input  logic [4:0] index_char,
  input  logic [7:0] data_mode0,
  input  logic [7:0] data_mode1,
  input  logic [7:0] data_mode2,
  input  logic [7:0] data_mode3,
  output logic [7:0] data_char,
  output logic [3:0] sw_mode0,
  output logic [3:0] sw_mode1,
  output logic [3:0] sw_mode2,
  output logic [3:0] sw_mode3,
  output logic [1:0] mode,
  output logic       busy,
  output logic       alarm_active,
  output logic       alarm_ack
);
  typedef enum logic [1:0] {OWN, SWITCH_WAIT, BLANK, ALARM} state_t;
  localparam logic [5:0] BLANK_LAST = 6'(BLANK_CHARS - 1);
  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SECS - 1);
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, target_q, target_d, dec_req, req;
  logic [5:0] blank_cnt_q, blank_cnt_d, sec_cnt_q, sec_cnt_d;
  logic [3:0] sw_q, sw_rise;
  logic pend_q, pend_d, alarm_q, alarm_rise;
  logic busy_q, busy_d, active_q, active_d, ack_q, ack_d;
  logic [7:0] owner_data;
  assign dec_req = dip_sw == 4'b0001 ? 2'd1 :
                   dip_sw == 4'b0010 ? 2'd2 :
                   dip_sw == 4'b0100 ? 2'd3 : 2'd0;
  assign sw_rise = sw_in & ~sw_q;
  assign alarm_rise = alarm_req & ~alarm_q;
`ifdef MODE_TIMEOUT_EN
  localparam logic [5:0] IDLE_LAST = 6'(IDLE_SECS - 1);
  logic idle_q, idle_d;
  logic [3:0] dip_q;
  assign req = idle_q ? 2'd0 : dec_req;
`else
  assign req = dec_req;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    target_d = target_q;
    pend_d = pend_q | alarm_rise;
    blank_cnt_d = blank_cnt_q;
    sec_cnt_d = sec_cnt_q;
    ack_d = 1'b0;
`ifdef MODE_TIMEOUT_EN
    idle_d = idle_q & (dip_sw == dip_q);
`endif
    case (state_q)
      OWN: begin
        if (alarm_rise || (pend_q && owner_q != 2'd3) || req != owner_q) begin
          target_d = (alarm_rise || pend_q) ? 2'd3 : req;
          state_d = SWITCH_WAIT;
        end else if (pend_q) begin
          state_d = ALARM;
          sec_cnt_d = '0;
        end
`ifdef MODE_TIMEOUT_EN
        // Stopwatch and watch modes never time out; only set and alarm-view do.
        if (owner_q == 2'd1 || owner_q == 2'd3) begin
          if (|sw_rise) sec_cnt_d = '0;
          else if (en_1hz) begin
            sec_cnt_d = sec_cnt_q == IDLE_LAST ? 6'd0 : sec_cnt_q + 6'd1;
            if (sec_cnt_q == IDLE_LAST) idle_d = 1'b1;
          end
        end else sec_cnt_d = '0;
`endif
      end
      SWITCH_WAIT: begin
        sec_cnt_d = '0;
        if (en_clk && index_char == 5'd31) begin
          state_d = BLANK;
          blank_cnt_d = '0;
        end
      end
      BLANK: begin
        if (en_clk) begin
          blank_cnt_d = blank_cnt_q + 6'd1;
          if (blank_cnt_q == BLANK_LAST) begin
            owner_d = target_q;
            state_d = (pend_d && target_q == 2'd3) ? ALARM : OWN;
            sec_cnt_d = '0;
          end
        end
      end
      ALARM: begin
        if (|sw_rise || (en_1hz && sec_cnt_q == ALARM_LAST)) begin
          ack_d = 1'b1;
          pend_d = 1'b0;
          target_d = dec_req;
          state_d = SWITCH_WAIT;
        end else if (en_1hz) sec_cnt_d = sec_cnt_q + 6'd1;
      end
    endcase
    busy_d = state_d == SWITCH_WAIT || state_d == BLANK;
    active_d = state_d == ALARM;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OWN;
      owner_q <= '0;
      target_q <= '0;
      pend_q <= 1'b0;
      blank_cnt_q <= '0;
      sec_cnt_q <= '0;
      sw_q <= '0;
      alarm_q <= 1'b0;
      busy_q <= 1'b0;
      active_q <= 1'b0;
      ack_q <= 1'b0;
`ifdef MODE_TIMEOUT_EN
      idle_q <= 1'b0;
      dip_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      target_q <= target_d;
      pend_q <= pend_d;
      blank_cnt_q <= blank_cnt_d;
      sec_cnt_q <= sec_cnt_d;
      sw_q <= sw_in;
      alarm_q <= alarm_req;
      busy_q <= busy_d;
      active_q <= active_d;
      ack_q <= ack_d;
`ifdef MODE_TIMEOUT_EN
      idle_q <= idle_d;
      dip_q <= dip_sw;
`endif
    end
  end
  assign owner_data = owner_q == 2'd0 ? data_mode0 :
                      owner_q == 2'd1 ? data_mode1 :
                      owner_q == 2'd2 ? data_mode2 : data_mode3;
  always_comb begin
    data_char = state_q == BLANK ? 8'h20 : state_q == ALARM ? data_mode3 : owner_data;
    sw_mode0 = (state_q == OWN && owner_q == 2'd0) ? sw_in : 4'd0;
    sw_mode1 = (state_q == OWN && owner_q == 2'd1) ? sw_in : 4'd0;
    sw_mode2 = (state_q == OWN && owner_q == 2'd2) ? sw_in : 4'd0;
    sw_mode3 = (state_q == OWN && owner_q == 2'd3) ? sw_in : 4'd0;
  end
  assign mode = owner_q;
  assign busy = busy_q;
  assign alarm_active = active_q;
  assign alarm_ack = ack_q;
endmodule
